alu_cond_flag_unit: RTL

Execute-stage back end of the multicycle ARM datapath. It sits directly downstream of the 32-bit ALU and performs three jobs:
- Registers the ALU result and evaluates the instruction's 4-bit condition code against the committed NZCV flags.
- Commits new flags when the S bit is set and the condition passes.
- Emits condition-gated write strobes to the control FSM.

Its committed C flag feeds the ALU carry-in for ADC/SBC.

---
 rtl/alu_cond_flag_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_cond_flag_unit.sv
// alu_cond_flag_unit
// Execute-stage back end for the multicycle ARM datapath. It registers the
// ALU result and evaluates the ARM condition field against the committed
// NZCV flags. Flags are committed on S & pass, and the unit emits
// condition-gated write strobes. Sequence: IDLE -> EVAL -> DONE -> IDLE.
//
// Optional feature macro: COND_NV_TRAP_EN
//   When defined, cond=1111 raises a one-cycle `undef` pulse in DONE.
//   When undefined, cond=1111 silently fails and the `undef` port is absent.
module alu_cond_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             shifter_carry,
  input  logic             is_logic,
  input  logic [3:0]       cond,
  input  logic             s_bit,
  input  logic             rw_req,
  input  logic             mw_req,
  input  logic             pcw_req,
  output logic [WIDTH-1:0] aluout,
  output logic [3:0]       flags,
  output logic             carry_to_alu,
  output logic             cond_ex,
  output logic             done,
  output logic             reg_write,
  output logic             mem_write,
`ifdef COND_NV_TRAP_EN
  output logic             undef,
`endif
  output logic             pc_write
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg;

  // Instruction fields captured when the request is accepted
  logic       n_reg, z_reg, c_reg, v_reg;
  logic       sc_reg, logic_reg, s_reg;
  logic       rw_reg, mw_reg, pcw_reg;
  logic [3:0] cond_reg;

  logic       pass;

  // ARM condition evaluation; f is {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = !cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cy & !z;
      4'b1001: cond_pass = !cy | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // 1111: never
    endcase
  endfunction

  // Pass/fail uses the flags as committed before this instruction updates them
  always_comb begin
    pass = cond_pass(cond_reg, flags);
  end

  assign ready        = (state_reg == IDLE);
  assign carry_to_alu = flags[1];

  // Sequencer, operand capture, flag commit and one-cycle output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      aluout    <= '0;
      flags     <= 4'b0000;
      cond_ex   <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      pc_write  <= 1'b0;
`ifdef COND_NV_TRAP_EN
      undef     <= 1'b0;
`endif
      n_reg     <= 1'b0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      sc_reg    <= 1'b0;
      logic_reg <= 1'b0;
      s_reg     <= 1'b0;
      rw_reg    <= 1'b0;
      mw_reg    <= 1'b0;
      pcw_reg   <= 1'b0;
      cond_reg  <= 4'b0000;
    end else begin
      // Pulses are high for exactly the DONE cycle
      done      <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      pc_write  <= 1'b0;
`ifdef COND_NV_TRAP_EN
      undef     <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (req) begin
            aluout    <= alu_result;
            n_reg     <= alu_n;
            z_reg     <= alu_z;
            c_reg     <= alu_c;
            v_reg     <= alu_v;
            sc_reg    <= shifter_carry;
            logic_reg <= is_logic;
            s_reg     <= s_bit;
            rw_reg    <= rw_req;
            mw_reg    <= mw_req;
            pcw_reg   <= pcw_req;
            cond_reg  <= cond;
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          cond_ex <= pass;
          if (pass && s_reg) begin
            // Logic ops take C from the shifter and leave V untouched
            if (logic_reg) begin
              flags <= {n_reg, z_reg, sc_reg, flags[0]};
            end else begin
              flags <= {n_reg, z_reg, c_reg, v_reg};
            end
          end
          done      <= 1'b1;
          reg_write <= rw_reg & pass;
          mem_write <= mw_reg & pass;
          pc_write  <= pcw_reg & pass;
`ifdef COND_NV_TRAP_EN
          undef     <= (cond_reg == 4'b1111);
`endif
          state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
